// File: rtl/sevenseg_pkg.sv
// Shared constants and types for the 8-digit multiplexed 7-segment scan driver.
// Segment patterns are active-low in {g,f,e,d,c,b,a} order.
package sevenseg_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    // Entry 15 first so that HEX_SEG[n] is the pattern for nibble n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic [1:0] {
        IDLE,
        CONV0,
        CONV1,
        COMMIT
    } conv_state_e;

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative 14-bit binary to 4-digit BCD converter (shift-and-add-3), one bit per cycle.
// Compiled only when DISP_BCD_EN is defined; done pulses 14 cycles after start.
`ifdef DISP_BCD_EN
module bin2bcd_iter (
    input  logic        clock,
    input  logic        clrn,
    input  logic        start,
    input  logic [13:0] bin,
    output logic [15:0] bcd,
    output logic        done,
    output logic        overflow
);

    logic [13:0] shift_q;
    logic [15:0] bcd_q;
    logic [3:0]  step_cnt;
    logic        busy;

    logic [13:0] src_bin;
    logic [15:0] src_bcd;
    logic [15:0] adj_bcd;
    logic [15:0] next_bcd;
    logic [13:0] next_shift;

    // The start cycle performs the first step on the fresh input, so no idle load cycle is needed.
    always_comb begin
        src_bin = start ? bin : shift_q;
        src_bcd = start ? 16'h0000 : bcd_q;
        adj_bcd = src_bcd;
        for (int d = 0; d < 4; d++) begin
            if (src_bcd[d*4 +: 4] >= 4'd5) begin
                adj_bcd[d*4 +: 4] = src_bcd[d*4 +: 4] + 4'd3;
            end
        end
        next_bcd   = {adj_bcd[14:0], src_bin[13]};
        next_shift = {src_bin[12:0], 1'b0};
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            shift_q  <= '0;
            bcd_q    <= '0;
            step_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else if (start) begin
            shift_q  <= next_shift;
            bcd_q    <= next_bcd;
            step_cnt <= 4'd1;
            busy     <= 1'b1;
            done     <= 1'b0;
            overflow <= (bin > 14'd9999);
        end else if (busy) begin
            shift_q  <= next_shift;
            bcd_q    <= next_bcd;
            step_cnt <= step_cnt + 4'd1;
            busy     <= (step_cnt != 4'd13);
            done     <= (step_cnt == 4'd13);
        end else begin
            done <= 1'b0;
        end
    end

    assign bcd = bcd_q;

endmodule
`endif

// File: rtl/sevenseg_scan_driver.sv
// Scans two CPU output ports onto an 8-digit common-anode display, snapshotting once per frame.
// Define DISP_BCD_EN to show the ports as 4-digit decimal (dashes above 9999) instead of hex.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int NUM_DIGITS = sevenseg_pkg::NUM_DIGITS
) (
    input  logic        clock,
    input  logic        clrn,
    input  logic [31:0] out_port0,
    input  logic [31:0] out_port1,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        frame_tick
);

    localparam int PRESC_W = $clog2(SCAN_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);

    if (NUM_DIGITS != sevenseg_pkg::NUM_DIGITS) begin : g_bad_digits
        $error("sevenseg_scan_driver: NUM_DIGITS must be 8");
    end
    if (SCAN_DIV < 2 || SCAN_DIV > (1 << 20)) begin : g_bad_div
        $error("sevenseg_scan_driver: SCAN_DIV out of range 2..2^20");
    end

    logic [PRESC_W-1:0] presc_q;
    logic [2:0]         digit_idx;
    logic               digit_wrap;
    logic               boundary;

    logic [15:0] disp0_q, disp1_q;
    logic        dash0_q, dash1_q;

    assign digit_wrap = (presc_q == PRESC_LAST);
    assign boundary   = digit_wrap && (digit_idx == 3'd7);

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            presc_q    <= '0;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
        end else begin
            presc_q    <= digit_wrap ? '0 : presc_q + 1'b1;
            digit_idx  <= digit_wrap ? digit_idx + 3'd1 : digit_idx;
            frame_tick <= boundary;
        end
    end

`ifdef DISP_BCD_EN
    if (SCAN_DIV * 8 < 32) begin : g_bad_bcd_div
        $error("sevenseg_scan_driver: SCAN_DIV*8 must be >= 32 with DISP_BCD_EN");
    end

    conv_state_e state_q, state_d;
    logic        conv_start, conv_done, conv_ovf;
    logic [13:0] conv_in, raw1_q;
    logic [15:0] conv_bcd, pend0_q;
    logic        pend_dash0_q;
    logic        unused_port_bits;

    assign unused_port_bits = ^{out_port0[31:14], out_port1[31:14]};

    // Port 0 goes straight into the converter at the boundary; port 1 waits in raw1_q.
    assign conv_in = (state_q == IDLE) ? out_port0[13:0] : raw1_q;

    bin2bcd_iter u_bin2bcd (
        .clock    (clock),
        .clrn     (clrn),
        .start    (conv_start),
        .bin      (conv_in),
        .bcd      (conv_bcd),
        .done     (conv_done),
        .overflow (conv_ovf)
    );

    always_comb begin
        state_d    = state_q;
        conv_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (boundary) begin
                    conv_start = 1'b1;
                    state_d    = CONV0;
                end
            end
            CONV0: begin
                if (conv_done) begin
                    conv_start = 1'b1;
                    state_d    = CONV1;
                end
            end
            CONV1: begin
                if (conv_done) begin
                    state_d = COMMIT;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Both halves are written together in COMMIT so the display never mixes two frames.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state_q      <= IDLE;
            raw1_q       <= '0;
            pend0_q      <= '0;
            pend_dash0_q <= 1'b0;
            disp0_q      <= '0;
            disp1_q      <= '0;
            dash0_q      <= 1'b0;
            dash1_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && boundary) begin
                raw1_q <= out_port1[13:0];
            end
            if (state_q == CONV0 && conv_done) begin
                pend0_q      <= conv_bcd;
                pend_dash0_q <= conv_ovf;
            end
            if (state_q == COMMIT) begin
                disp0_q <= pend0_q;
                dash0_q <= pend_dash0_q;
                disp1_q <= conv_bcd;
                dash1_q <= conv_ovf;
            end
        end
    end
`else
    logic unused_port_bits;

    assign unused_port_bits = ^{out_port0[31:16], out_port1[31:16]};
    assign dash0_q = 1'b0;
    assign dash1_q = 1'b0;

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            disp0_q <= '0;
            disp1_q <= '0;
        end else if (boundary) begin
            disp0_q <= out_port0[15:0];
            disp1_q <= out_port1[15:0];
        end
    end
`endif

    logic [15:0] cur_word;
    logic        cur_dash;
    logic [3:0]  cur_nib;

    always_comb begin
        cur_word = digit_idx[2] ? disp1_q : disp0_q;
        cur_dash = digit_idx[2] ? dash1_q : dash0_q;
        cur_nib  = cur_word[{digit_idx[1:0], 2'b00} +: 4];
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            an  <= 8'hFF;
            seg <= SEG_OFF;
        end else begin
            an  <= ~(8'b0000_0001 << digit_idx);
            seg <= cur_dash ? SEG_DASH : HEX_SEG[cur_nib];
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed self-checking bench for sevenseg_scan_driver with SCAN_DIV=4 (32-cycle frames).
// Covers reset, scan order, hex decoding, per-frame snapshots, async reset and the BCD build.
module tb_sevenseg_scan_driver;

    localparam int TB_DIV = 4;

    logic        clock;
    logic        clrn;
    logic [31:0] out_port0, out_port1;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        frame_tick;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    sevenseg_scan_driver #(.SCAN_DIV(TB_DIV)) dut (
        .clock      (clock),
        .clrn       (clrn),
        .out_port0  (out_port0),
        .out_port1  (out_port1),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [6:0] segOf(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Expected segment pattern per digit index for the two 4-nibble halves.
    function automatic logic [7:0][6:0] buildExp(input logic [15:0] w0, input logic [15:0] w1,
                                                 input logic d0, input logic d1);
        logic [7:0][6:0] r;
        logic [15:0]     w;
        for (int i = 0; i < 8; i++) begin
            w = (i < 4) ? w0 : w1;
            if ((i < 4) ? d0 : d1) r[i] = 7'h3F;
            else                   r[i] = segOf(w[(i % 4) * 4 +: 4]);
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at t=%0t cyc=%0d: observed %0h expected %0h",
                     tag, $time, cyc, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] p0, input logic [31:0] p1);
        out_port0 = p0;
        out_port1 = p1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_an"},  {24'h0, an},  32'hFF);
        checkOutput({tag, "_seg"}, {25'h0, seg}, 32'h7F);
        checkOutput({tag, "_ft"},  {31'h0, frame_tick}, 32'h0);
    endtask

    task automatic releaseReset();
        @(negedge clock);
        clrn = 1'b1;
        cyc  = 0;
    endtask

    // Each cycle: anode for digit ((cyc-1)/DIV)%8, its segments, and the frame pulse every 32 cycles.
    task automatic runCycles(input int n, input logic [7:0][6:0] exp);
        int         idx;
        logic [7:0] exp_an;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
            idx    = ((cyc - 1) / TB_DIV) % 8;
            exp_an = ~(8'b0000_0001 << idx);
            checkOutput("an",  {24'h0, an},  {24'h0, exp_an});
            checkOutput("seg", {25'h0, seg}, {25'h0, exp[idx]});
            checkOutput("frame_tick", {31'h0, frame_tick},
                        {31'h0, ((cyc % (8 * TB_DIV)) == 0)});
        end
    endtask

    logic [7:0][6:0] all_zero;

    initial begin
        all_zero = buildExp(16'h0000, 16'h0000, 1'b0, 1'b0);
        clrn = 1'b0;
`ifdef DISP_BCD_EN
        applyStimulus(32'd1234, 32'd10000);
`else
        applyStimulus(32'h0000_1234, 32'h0000_ABCD);
`endif
        repeat (3) @(negedge clock);
        checkResetState("reset");
        releaseReset();
        runCycles(32, all_zero);

`ifdef DISP_BCD_EN
        // Commit lands 29 cycles after the boundary edge; segments follow one cycle later.
        runCycles(29, all_zero);
        runCycles(35, buildExp(16'h1234, 16'h0000, 1'b0, 1'b1));
        applyStimulus(32'd0, 32'd9999);
        runCycles(61, buildExp(16'h1234, 16'h0000, 1'b0, 1'b1));
        runCycles(40, buildExp(16'h0000, 16'h9999, 1'b0, 1'b0));
        #2 clrn = 1'b0;
        #1 checkResetState("midconv_reset");
        repeat (2) @(negedge clock);
        checkResetState("midconv_hold");
        releaseReset();
        runCycles(61, all_zero);
        runCycles(10, buildExp(16'h0000, 16'h9999, 1'b0, 1'b0));
`else
        runCycles(16, buildExp(16'h1234, 16'hABCD, 1'b0, 1'b0));
        applyStimulus(32'h0000_1111, 32'h0000_ABCD);
        runCycles(16, buildExp(16'h1234, 16'hABCD, 1'b0, 1'b0));
        runCycles(8,  buildExp(16'h1111, 16'hABCD, 1'b0, 1'b0));
        applyStimulus(32'h0000_5555, 32'h0000_ABCD);
        runCycles(8,  buildExp(16'h1111, 16'hABCD, 1'b0, 1'b0));
        applyStimulus(32'h0000_2222, 32'h0000_ABCD);
        runCycles(16, buildExp(16'h1111, 16'hABCD, 1'b0, 1'b0));
        runCycles(20, buildExp(16'h2222, 16'hABCD, 1'b0, 1'b0));
        #2 clrn = 1'b0;
        #1 checkResetState("midframe_reset");
        repeat (2) @(negedge clock);
        checkResetState("midframe_hold");
        releaseReset();
        runCycles(32, all_zero);
        runCycles(32, buildExp(16'h2222, 16'hABCD, 1'b0, 1'b0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
